// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, frame state encoding and default timing.
package uart_pkg;

    localparam int unsigned DEF_DIV    = 10;
    localparam int unsigned DEF_OS     = 16;
    localparam int unsigned MAX_DATA_W = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Only the first len bits contribute; bits above the frame length are ignored.
    function automatic logic par_calc(input logic [MAX_DATA_W-1:0] data,
                                      input logic [3:0] len,
                                      input parity_t mode);
        logic x;
        x = 1'b0;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (i < 32'(len)) x ^= data[i];
        end
        case (mode)
            PAR_EVEN: return x;
            PAR_ODD:  return ~x;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks, restartable via clr.
module uart_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: per-frame length, parity and stop bits, valid/ready intake.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV    = DEF_DIV,
    parameter int unsigned OS     = DEF_OS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cfg_len,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              txd
);

    localparam int unsigned    OSW     = $clog2(OS);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OS - 1);
    localparam logic [3:0]     LEN_MAX = 4'(DATA_W);

    state_t            state;
    logic [OSW-1:0]    os_cnt;
    logic [3:0]        bit_cnt;
    logic [3:0]        n_len;
    logic [3:0]        len_clamped;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              par_en;
    logic              stop2;
    logic              tick;
    logic              accept;

    assign accept = tx_valid && tx_ready;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len < 4'd5) begin
            len_clamped = 4'd5;
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    uart_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            n_len    <= 4'd5;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            stop2    <= 1'b0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_ready <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    txd      <= 1'b1;
                    if (accept) begin
                        state    <= START;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        txd      <= 1'b0;
                        os_cnt   <= '0;
                        bit_cnt  <= '0;
                        shreg    <= tx_data;
                        n_len    <= len_clamped;
                        par_en   <= (parity_t'(cfg_parity) != PAR_NONE);
                        par_bit  <= par_calc(MAX_DATA_W'(tx_data), len_clamped,
                                             parity_t'(cfg_parity));
                        stop2    <= cfg_stop2;
                    end
                end
                default: begin
                    if (tick) begin
                        if (os_cnt != OS_LAST) begin
                            os_cnt <= os_cnt + 1'b1;
                        end else begin
                            os_cnt <= '0;
                            case (state)
                                START: begin
                                    state   <= DATA;
                                    txd     <= shreg[0];
                                    bit_cnt <= '0;
                                end
                                DATA: begin
                                    shreg <= shreg >> 1;
                                    if (bit_cnt == n_len - 4'd1) begin
                                        bit_cnt <= '0;
                                        if (par_en) begin
                                            state <= PARITY;
                                            txd   <= par_bit;
                                        end else begin
                                            state <= STOP;
                                            txd   <= 1'b1;
                                        end
                                    end else begin
                                        bit_cnt <= bit_cnt + 4'd1;
                                        txd     <= shreg[1];
                                    end
                                end
                                PARITY: begin
                                    state   <= STOP;
                                    txd     <= 1'b1;
                                    bit_cnt <= '0;
                                end
                                STOP: begin
                                    // bit_cnt doubles as the stop-bit counter for two-stop frames
                                    if (stop2 && bit_cnt == 4'd0) begin
                                        bit_cnt <= 4'd1;
                                    end else begin
                                        state    <= IDLE;
                                        tx_busy  <= 1'b0;
                                        tx_done  <= 1'b1;
                                        tx_ready <= 1'b1;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
